// File: rtl/ram_loader_pkg.sv
// Shared defaults, FSM encoding and byte-order helper for the boot-time RAM loader.
package ram_loader_pkg;

    localparam int ADDR_W_DEF     = 8;
    localparam int DATA_W_DEF     = 16;
    localparam int LOAD_WORDS_DEF = 256;
    localparam int BYTE_W         = 8;

    // Stream order: the first byte of each pair is the high byte of the word.
    localparam bit HI_BYTE_FIRST  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HI     = 3'd1,
        ST_LO     = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4,
        ST_CHK_HI = 3'd5,
        ST_CHK_LO = 3'd6
    } state_t;

    function automatic logic [2*BYTE_W-1:0] pack_word(input logic [BYTE_W-1:0] first,
                                                      input logic [BYTE_W-1:0] second);
        return HI_BYTE_FIRST ? {first, second} : {second, first};
    endfunction

endpackage

// File: rtl/ram_port_mux.sv
// Purely combinational select of loader or CPU onto the RAM write port (sel=1 -> loader).
// Zero latency; no backpressure.
module ram_port_mux #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              sel,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_we,
    input  logic [DATA_W-1:0] ld_d,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_d,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_d
);

    assign ram_addr = sel ? ld_addr : cpu_addr;
    assign ram_we   = sel ? ld_we   : cpu_we;
    assign ram_d    = sel ? ld_d    : cpu_d;

endmodule

// File: rtl/ram_loader.sv
// Byte-stream to 16-bit RAM loader: 3 cycles/word minimum, stalls on in_valid=0 without losing data.
// Optional trailing checksum word under LOADER_CHECKSUM_EN; CPU owns the RAM port whenever not busy.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LOAD_WORDS = LOAD_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_d,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_d,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              checksum_err
);

    localparam int LAST_INT = LOAD_WORDS - 1;
    localparam logic [ADDR_W:0] LAST_IDX = LAST_INT[ADDR_W:0];

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     wcnt_q;
    logic [7:0]          hi_q, lo_q;
    logic                ld_we;
    logic [DATA_W-1:0]   ld_d;

    assign ld_d       = DATA_W'(pack_word(hi_q, lo_q));
    assign word_count = wcnt_q;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        ld_we    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                done = (state_q == ST_DONE);
                if (start) state_d = ST_HI;
            end
            ST_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_d = ST_LO;
            end
            ST_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                busy  = 1'b1;
                ld_we = 1'b1;
                if (wcnt_q == LAST_IDX) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = ST_CHK_HI;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_d = ST_CHK_LO;
            end
            ST_CHK_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_d = ST_DONE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wcnt_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        addr_q <= '0;
                        wcnt_q <= '0;
                    end
                end
                ST_HI:    if (in_valid) hi_q <= in_byte;
                ST_LO:    if (in_valid) lo_q <= in_byte;
                ST_WRITE: begin
                    // addr_q is ADDR_W wide, so a full-depth load wraps it back to 0.
                    addr_q <= addr_q + ADDR_W'(1);
                    wcnt_q <= wcnt_q + (ADDR_W+1)'(1);
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHK_HI: if (in_valid) hi_q <= in_byte;
`endif
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;
    logic              chk_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q    <= '0;
            chk_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        csum_q    <= '0;
                        chk_err_q <= 1'b0;
                    end
                end
                ST_WRITE:  csum_q <= csum_q + ld_d;
                ST_CHK_LO: if (in_valid) chk_err_q <= (DATA_W'(pack_word(hi_q, in_byte)) != csum_q);
                default: ;
            endcase
        end
    end

    assign checksum_err = chk_err_q;
`else
    assign checksum_err = 1'b0;
`endif

    ram_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .sel      (busy),
        .ld_addr  (addr_q),
        .ld_we    (ld_we),
        .ld_d     (ld_d),
        .cpu_addr (cpu_addr),
        .cpu_we   (cpu_we),
        .cpu_d    (cpu_d),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_d    (ram_d)
    );

endmodule
